axi4_burst_sram_slave: RTL

AXI4_BURST_SRAM_SLAVE -- requirements
Module: axi4_burst_sram_slave

---
 rtl/axi4_burst_sram_slave.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_sram_slave.sv
// axi4_burst_sram_slave: AXI4 burst slave in front of an on-chip word SRAM.
// Only one burst is in flight at a time, and one FSM serves both the write and read paths.
// Optional feature: when the macro AXI_SLV_RR_ARB_EN is defined, simultaneous AW/AR requests
// are granted round-robin. When it is undefined (the default), a write always wins a tie.
module axi4_burst_sram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);

    localparam int               IDX_W       = ADDR_WIDTH - 2;
    localparam int               MEM_AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX   = IDX_W'(MEM_DEPTH);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [7:0]            len;
    logic [7:0]            beat_cnt;
    logic [1:0]            burst;
    logic                  err;
    logic                  prefer_write;
    logic                  aw_grant;
    logic                  ar_grant;
    logic                  last_beat;
    logic                  cur_oor;
    logic                  nxt_oor;
    logic                  ar_oor;
    logic                  beat_err;
    logic                  mem_we;

    // FIXED holds the address. Every other burst type advances by one 32-bit word.
    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0]            b);
        return (b == 2'b00) ? a : a + ADDR_WIDTH'(4);
    endfunction

    // A burst is in error when its size is not 4 bytes, or its type is WRAP or reserved.
    function automatic logic attr_err(input logic [2:0] size, input logic [1:0] b);
        return (size != 3'b010) || b[1];
    endfunction

    // Grant, range, and beat-status decode. Only the grant goes to the ready ports.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        aw_grant  = !reset && (state == IDLE) && axi_awvalid && (!axi_arvalid || prefer_write);
        ar_grant  = !reset && (state == IDLE) && axi_arvalid && !aw_grant;
        nxt_addr  = step_addr(addr, burst);
        cur_oor   = addr[ADDR_WIDTH-1:2] >= DEPTH_IDX;
        nxt_oor   = nxt_addr[ADDR_WIDTH-1:2] >= DEPTH_IDX;
        ar_oor    = axi_araddr[ADDR_WIDTH-1:2] >= DEPTH_IDX;
        last_beat = (beat_cnt == len);
        beat_err  = cur_oor || (axi_wlast != last_beat);
        mem_we    = !reset && (state == WDATA) && axi_wvalid && !cur_oor;
    end

    assign axi_awready = aw_grant;
    assign axi_arready = ar_grant;
    assign axi_wready  = !reset && (state == WDATA);

`ifdef AXI_SLV_RR_ARB_EN
    // Round-robin pointer: after any grant, the other channel wins the next tie.
    always_ff @(posedge clk) begin
        if (reset)         prefer_write <= 1'b1;
        else if (aw_grant) prefer_write <= 1'b0;
        else if (ar_grant) prefer_write <= 1'b1;
    end
`else
    assign prefer_write = 1'b1;
`endif

    // SRAM write port. Out-of-range beats are dropped by the enable.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Its contents survive a reset by design.
        if (mem_we) mem[addr[MEM_AW+1:2]] <= axi_wdata;
    end

    // Burst FSM. It owns every registered output and the per-burst bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments, so update order cannot matter.
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            len        <= '0;
            burst      <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
            axi_bvalid <= 1'b0;
            axi_bresp  <= RESP_OKAY;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= RESP_OKAY;
            axi_rlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (aw_grant) begin
                        addr  <= axi_awaddr;
                        len   <= axi_awlen;
                        burst <= axi_awburst;
                        err   <= attr_err(axi_awsize, axi_awburst);
                        state <= WDATA;
                    end else if (ar_grant) begin
                        addr       <= axi_araddr;
                        len        <= axi_arlen;
                        burst      <= axi_arburst;
                        err        <= attr_err(axi_arsize, axi_arburst);
                        axi_rvalid <= 1'b1;
                        axi_rdata  <= ar_oor ? '0 : mem[axi_araddr[MEM_AW+1:2]];
                        axi_rresp  <= (ar_oor || attr_err(axi_arsize, axi_arburst)) ?
                                      RESP_SLVERR : RESP_OKAY;
                        axi_rlast  <= (axi_arlen == 8'd0);
                        state      <= RDATA;
                    end
                end
                WDATA: begin
                    if (axi_wvalid) begin
                        addr     <= nxt_addr;
                        beat_cnt <= beat_cnt + 8'd1;
                        err      <= err || beat_err;
                        if (last_beat) begin
                            axi_bvalid <= 1'b1;
                            axi_bresp  <= (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state      <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (axi_bready) begin
                        axi_bvalid <= 1'b0;
                        axi_bresp  <= RESP_OKAY;
                        state      <= IDLE;
                    end
                end
                RDATA: begin
                    if (axi_rready) begin
                        if (axi_rlast) begin
                            axi_rvalid <= 1'b0;
                            axi_rlast  <= 1'b0;
                            axi_rdata  <= '0;
                            axi_rresp  <= RESP_OKAY;
                            state      <= IDLE;
                        end else begin
                            addr      <= nxt_addr;
                            beat_cnt  <= beat_cnt + 8'd1;
                            axi_rdata <= nxt_oor ? '0 : mem[nxt_addr[MEM_AW+1:2]];
                            axi_rresp <= (nxt_oor || err) ? RESP_SLVERR : RESP_OKAY;
                            axi_rlast <= ((beat_cnt + 8'd1) == len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
